ace_ccu_snoop_resp: RTL and testbench
=====================================

ACE_CCU_SNOOP_RESP -- requirements
Module: ace_ccu_snoop_resp

Interface
REQ-001 Parameter NumInp, default 1: number of snoop initiators (response destinations), range 1..16.
REQ-002 Parameter NumOup, default 1: number of snooped masters (CR sources), range 1..16.
REQ-003 Parameter CtrlDepth, default 2: depth of the control FIFO, range 1..8.
REQ-004 Parameter IdxW, default max(1,$clog2(NumInp)): width of the initiator index.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset; asynchronous assertion, active-high.
REQ-007 ctrl_valid_i  input  1  control entry valid, from the snoop request stage.
REQ-008 ctrl_ready_o  output  1  control entry accepted.
REQ-009 ctrl_sel_i  input  NumOup  one bit per snooped master that must return a CR.
REQ-010 ctrl_idx_i  input  IdxW  initiator receiving the combined response.
REQ-011 cr_valids_i  input  NumOup  per-master CR valid.
REQ-012 cr_readies_o  output  NumOup  per-master CR ready.
REQ-013 cr_resps_i  input  NumOup x 5  per-master CRRESP {WasUnique,IsShared,PassDirty,Error,DataTransfer} (bit4..bit0).
REQ-014 cr_valids_o  output  NumInp  one-hot combined response valid toward initiators.
REQ-015 cr_readies_i  input  NumInp  per-initiator ready.
REQ-016 cr_resp_o  output  5  combined CRRESP, shared by all initiators.
REQ-017 busy_o  output  1  high while the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 Control FIFO: CtrlDepth entries of {sel,idx}; ctrl_ready_o = not full; push on ctrl_valid_i and ctrl_ready_o; no bypass, no push while full even if pop occurs that cycle.
REQ-019 FSM states IDLE, COLLECT, RESP; one transaction in flight at a time, in FIFO order.
REQ-020 IDLE: if FIFO non-empty, latch head sel into pend, clear got mask and acc, go COLLECT next cycle; else stay.
REQ-021 COLLECT: cr_readies_o[j] = pend[j] and not got[j]; all other cr_readies_o bits 0; masters not in pend are never acknowledged.
REQ-022 COLLECT: each CR handshake sets got[j] and ORs cr_resps_i[j] into acc bitwise; several masters in the same cycle are all accepted and merged.
REQ-023 COLLECT -> RESP in the cycle after got == pend (including the cycle the last handshake occurs); cr_resp_o = acc registered.
REQ-024 pend == 0: COLLECT lasts one cycle, then RESP with cr_resp_o = 0.
REQ-025 RESP: cr_valids_o[head idx] = 1, other bits 0; cr_resp_o stable while valid and not ready.
REQ-026 RESP handshake: pop FIFO; next state COLLECT with new head latched if FIFO holds another entry after pop, else IDLE.
REQ-027 Latency: control push in cycle N -> COLLECT earliest N+2 (IDLE sees entry at N+1); last CR handshake in cycle M -> cr_valids_o high at M+1.
REQ-028 ctrl_idx_i >= NumInp is illegal; behaviour unspecified; assertion in simulation.
REQ-029 Outputs cr_valids_o, cr_resp_o, cr_readies_o are driven from registered state only; no combinational path from cr_valids_i to cr_readies_o.

Reset
REQ-030 rst_i high asynchronously clears FIFO pointers and count, FSM to IDLE, pend, got, acc and cr_resp_o to 0.
REQ-031 During and after reset: ctrl_ready_o = 1, cr_readies_o = 0, cr_valids_o = 0, cr_resp_o = 0, busy_o = 0.
REQ-032 Reset mid-transaction discards in-flight and queued entries; no response is emitted for them.

Verification
REQ-033 NumOup=4, NumInp=2: push sel=4'b0101 idx=1; masters 0 and 2 return 5'b00001 and 5'b01000 in different cycles -> cr_valids_o=2'b10, cr_resp_o=5'b01001 one cycle after second CR; cr_readies_o[1],[3] never high.
REQ-034 Push sel=4'b1111 idx=0, all four CRs valid same cycle (5'b00100 on master 3, 0 elsewhere) -> all accepted in one cycle, next cycle cr_valids_o=2'b01, cr_resp_o=5'b00100.
REQ-035 CtrlDepth=2: push three entries while first CR withheld -> third push stalls (ctrl_ready_o=0) until first RESP handshake; responses emerge in push order.
REQ-036 Push sel=0 idx=1 -> cr_valids_o=2'b10, cr_resp_o=0 within 3 cycles of push; hold cr_readies_i low 5 cycles -> output stable.
REQ-037 Assert rst_i while in COLLECT with one CR collected -> next cycle all outputs at reset values, busy_o=0; after release a fresh transaction completes normally.

Source files
------------

// File: rtl/ace_ccu_snoop_resp.sv
// ACE CCU snoop response combiner: queues {sel,idx} control entries, collects the
// selected masters' CRRESPs, ORs them together and returns one response per entry.
module ace_ccu_snoop_resp #(
  parameter int unsigned NumInp    = 1,
  parameter int unsigned NumOup    = 1,
  parameter int unsigned CtrlDepth = 2,
  parameter int unsigned IdxW      = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ctrl_valid_i,
  output logic                   ctrl_ready_o,
  input  logic [NumOup-1:0]      ctrl_sel_i,
  input  logic [IdxW-1:0]        ctrl_idx_i,
  input  logic [NumOup-1:0]      cr_valids_i,
  output logic [NumOup-1:0]      cr_readies_o,
  input  logic [NumOup-1:0][4:0] cr_resps_i,
  output logic [NumInp-1:0]      cr_valids_o,
  input  logic [NumInp-1:0]      cr_readies_i,
  output logic [4:0]             cr_resp_o,
  output logic                   busy_o
);

  localparam int unsigned PtrW = (CtrlDepth > 1) ? $clog2(CtrlDepth) : 1;
  localparam int unsigned CntW = $clog2(CtrlDepth + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, RESP} state_e;

  state_e            state_q, state_d;
  logic [NumOup-1:0] pend_q, pend_d;
  logic [NumOup-1:0] got_q, got_d;
  logic [4:0]        acc_q, acc_d;
  logic [4:0]        resp_q, resp_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [NumOup-1:0] sel_mem_q [CtrlDepth];
  logic [IdxW-1:0]   idx_mem_q [CtrlDepth];

  logic              full;
  logic              push;
  logic              pop;
  logic              resp_hs;
  logic [NumOup-1:0] cr_hs;
  logic [NumOup-1:0] got_merge;
  logic [4:0]        acc_merge;
  logic [PtrW-1:0]   rd_ptr_inc;
  logic [PtrW-1:0]   wr_ptr_inc;

  assign full         = (count_q == CntW'(CtrlDepth));
  assign ctrl_ready_o = ~full;
  assign push         = ctrl_valid_i & ~full;
  assign busy_o       = (state_q != IDLE) || (count_q != '0);
  assign cr_resp_o    = resp_q;
  assign cr_readies_o = (state_q == COLLECT) ? (pend_q & ~got_q) : '0;
  assign cr_hs        = cr_valids_i & cr_readies_o;
  assign got_merge    = got_q | cr_hs;
  assign resp_hs      = |(cr_valids_o & cr_readies_i);

  assign rd_ptr_inc = (rd_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
  assign wr_ptr_inc = (wr_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : wr_ptr_q + 1'b1;

  always_comb begin
    cr_valids_o = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      cr_valids_o[i] = (state_q == RESP) && (idx_q == IdxW'(i));
    end
  end

  always_comb begin
    acc_merge = acc_q;
    for (int unsigned j = 0; j < NumOup; j++) begin
      if (cr_hs[j]) acc_merge = acc_merge | cr_resps_i[j];
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    got_d   = got_q;
    acc_d   = acc_q;
    resp_d  = resp_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pend_d  = sel_mem_q[rd_ptr_q];
          idx_d   = idx_mem_q[rd_ptr_q];
          got_d   = '0;
          acc_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        got_d = got_merge;
        acc_d = acc_merge;
        // An empty selection also satisfies this on the first cycle
        if (got_merge == pend_q) begin
          resp_d  = acc_merge;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          pop = 1'b1;
          if (count_q > CntW'(1)) begin
            pend_d  = sel_mem_q[rd_ptr_inc];
            idx_d   = idx_mem_q[rd_ptr_inc];
            got_d   = '0;
            acc_d   = '0;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_inc : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_inc : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      got_q    <= '0;
      acc_q    <= '0;
      resp_q   <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      got_q    <= got_d;
      acc_q    <= acc_d;
      resp_q   <= resp_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      sel_mem_q[wr_ptr_q] <= ctrl_sel_i;
      idx_mem_q[wr_ptr_q] <= ctrl_idx_i;
    end
  end

  idx_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> ({{(32 - IdxW){1'b0}}, ctrl_idx_i} < NumInp));

endmodule

// File: tb/tb_ace_ccu_snoop_resp.sv
// Directed bench for ace_ccu_snoop_resp with NumOup=4, NumInp=2, CtrlDepth=2.
module tb_ace_ccu_snoop_resp;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            ctrl_valid_i;
  logic            ctrl_ready_o;
  logic [3:0]      ctrl_sel_i;
  logic [0:0]      ctrl_idx_i;
  logic [3:0]      cr_valids_i;
  logic [3:0]      cr_readies_o;
  logic [3:0][4:0] cr_resps_i;
  logic [1:0]      cr_valids_o;
  logic [1:0]      cr_readies_i;
  logic [4:0]      cr_resp_o;
  logic            busy_o;

  int total = 0;
  int bad   = 0;

  ace_ccu_snoop_resp #(
    .NumInp(2), .NumOup(4), .CtrlDepth(2), .IdxW(1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .ctrl_valid_i(ctrl_valid_i),
    .ctrl_ready_o(ctrl_ready_o),
    .ctrl_sel_i(ctrl_sel_i),
    .ctrl_idx_i(ctrl_idx_i),
    .cr_valids_i(cr_valids_i),
    .cr_readies_o(cr_readies_o),
    .cr_resps_i(cr_resps_i),
    .cr_valids_o(cr_valids_o),
    .cr_readies_i(cr_readies_i),
    .cr_resp_o(cr_resp_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [3:0] sel, input logic idx,
                               input logic [3:0] crv, input logic [3:0][4:0] resps,
                               input logic [1:0] crr);
    ctrl_valid_i = cv;
    ctrl_sel_i   = sel;
    ctrl_idx_i   = idx;
    cr_valids_i  = crv;
    cr_resps_i   = resps;
    cr_readies_i = crr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrl_ready"}, 32'(ctrl_ready_o), 32'd1);
    checkOutput({tag, "_cr_readies"}, 32'(cr_readies_o), 32'd0);
    checkOutput({tag, "_cr_valids"},  32'(cr_valids_o),  32'd0);
    checkOutput({tag, "_cr_resp"},    32'(cr_resp_o),    32'd0);
    checkOutput({tag, "_busy"},       32'(busy_o),       32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    tick();
    tick();
    checkIdleOutputs("reset");
    rst_i = 1'b0;
    tick();
    checkIdleOutputs("post_reset");

    // Two masters answer in different cycles; an unselected master is ignored
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    checkOutput("t1_busy", 32'(busy_o), 32'd1);
    tick();
    checkOutput("t1_readies_a", 32'(cr_readies_o), 32'b0101);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0001, {5'b0, 5'b0, 5'b0, 5'b00001}, 2'b0);
    tick();
    checkOutput("t1_readies_b", 32'(cr_readies_o), 32'b0100);
    checkOutput("t1_no_early_valid", 32'(cr_valids_o), 32'b00);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0110, {5'b0, 5'b01000, 5'b10000, 5'b0}, 2'b0);
    tick();
    checkOutput("t1_valids", 32'(cr_valids_o), 32'b10);
    checkOutput("t1_resp", 32'(cr_resp_o), 32'b01001);
    checkOutput("t1_readies_c", 32'(cr_readies_o), 32'b0000);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b10);
    tick();
    checkOutput("t1_valids_done", 32'(cr_valids_o), 32'b00);
    checkOutput("t1_busy_done", 32'(busy_o), 32'd0);

    // All four masters in one cycle
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    tick();
    checkOutput("t2_readies", 32'(cr_readies_o), 32'b1111);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b1111, {5'b00100, 5'b0, 5'b0, 5'b0}, 2'b0);
    tick();
    checkOutput("t2_valids", 32'(cr_valids_o), 32'b01);
    checkOutput("t2_resp", 32'(cr_resp_o), 32'b00100);
    checkOutput("t2_readies_after", 32'(cr_readies_o), 32'b0000);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b01);
    tick();
    checkOutput("t2_valids_done", 32'(cr_valids_o), 32'b00);

    // FIFO full: third push stalls until the first response handshake
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0, '0, 2'b0);
    tick();
    checkOutput("t3_full_a", 32'(ctrl_ready_o), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0, '0, 2'b0);
    tick();
    checkOutput("t3_full_b", 32'(ctrl_ready_o), 32'd0);
    checkOutput("t3_readies_a", 32'(cr_readies_o), 32'b0001);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0001, {5'b0, 5'b0, 5'b0, 5'b00010}, 2'b0);
    tick();
    checkOutput("t3_valids_a", 32'(cr_valids_o), 32'b01);
    checkOutput("t3_resp_a", 32'(cr_resp_o), 32'b00010);
    checkOutput("t3_full_c", 32'(ctrl_ready_o), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0, '0, 2'b01);
    tick();
    checkOutput("t3_ready_after_pop", 32'(ctrl_ready_o), 32'd1);
    checkOutput("t3_readies_b", 32'(cr_readies_o), 32'b0010);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0010, {5'b0, 5'b0, 5'b10000, 5'b0}, 2'b0);
    tick();
    checkOutput("t3_valids_b", 32'(cr_valids_o), 32'b10);
    checkOutput("t3_resp_b", 32'(cr_resp_o), 32'b10000);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b10);
    tick();
    checkOutput("t3_readies_c", 32'(cr_readies_o), 32'b0100);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0100, {5'b0, 5'b00001, 5'b0, 5'b0}, 2'b0);
    tick();
    checkOutput("t3_valids_c", 32'(cr_valids_o), 32'b01);
    checkOutput("t3_resp_c", 32'(cr_resp_o), 32'b00001);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b01);
    tick();
    checkOutput("t3_busy_done", 32'(busy_o), 32'd0);

    // Empty selection; response held while the initiator stalls
    applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t4_valids_%0d", k), 32'(cr_valids_o), 32'b10);
      checkOutput($sformatf("t4_resp_%0d", k), 32'(cr_resp_o), 32'b00000);
      if (k < 5) tick();
    end
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b10);
    tick();
    checkOutput("t4_valids_done", 32'(cr_valids_o), 32'b00);

    // Reset mid-collection, then a fresh transaction
    applyStimulus(1'b1, 4'b0011, 1'b0, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0001, {5'b0, 5'b0, 5'b0, 5'b00001}, 2'b01);
    tick();
    checkOutput("t5_readies_pre", 32'(cr_readies_o), 32'b0010);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b01);
    rst_i = 1'b1;
    #1;
    checkIdleOutputs("t5_in_reset");
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    checkIdleOutputs("t5_after_reset");
    applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0, '0, 2'b0);
    tick();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b0);
    tick();
    checkOutput("t5_readies", 32'(cr_readies_o), 32'b0010);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0010, {5'b0, 5'b0, 5'b01000, 5'b0}, 2'b0);
    tick();
    checkOutput("t5_valids", 32'(cr_valids_o), 32'b10);
    checkOutput("t5_resp", 32'(cr_resp_o), 32'b01000);
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0, '0, 2'b10);
    tick();
    checkOutput("t5_busy_done", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
